// File: rtl/ddr_cmd_sequencer.sv
// Serialises read/write/refresh requests into legal DDR command sequences, one command in flight.
// Strobes registered (first command one cycle after acceptance); req_ready held low until the sequence completes.
module ddr_cmd_sequencer #(
   parameter int BGWIDTH  = 2,
   parameter int BAWIDTH  = 2,
   parameter int ROWWIDTH = 16,
   parameter int BL       = 8,
   parameter int T_RCD    = 17,
   parameter int T_RP     = 17,
   parameter int T_WR     = 14,
   parameter int T_RFC    = 34
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 req_valid,
   output logic                                 req_ready,
   input  logic                                 req_write,
   input  logic                                 req_autopre,
   input  logic [(BGWIDTH > 0 ? BGWIDTH : 1)-1:0] req_bg,
   input  logic [BAWIDTH-1:0]                   req_ba,
   input  logic [ROWWIDTH-1:0]                  req_row,
   input  logic                                 ref_req,
   output logic                                 ref_ack,
   output logic                                 ACT,
   output logic                                 PR,
   output logic                                 PRA,
   output logic                                 RD,
   output logic                                 RDA,
   output logic                                 WR,
   output logic                                 WRA,
   output logic                                 REF,
   output logic [(BGWIDTH > 0 ? BGWIDTH : 1)-1:0] cmd_bg,
   output logic [BAWIDTH-1:0]                   cmd_ba,
   output logic [ROWWIDTH-1:0]                  cmd_row,
   output logic                                 resp_valid,
   output logic                                 resp_write
);
   localparam int BGW   = (BGWIDTH > 0) ? BGWIDTH : 1;
   localparam int IDXW  = BGWIDTH + BAWIDTH;
   localparam int NBANK = 1 << IDXW;
   localparam int T_A   = (T_RFC > BL + T_RP) ? T_RFC : BL + T_RP;
   localparam int T_B   = (T_WR + T_RP > T_RCD) ? T_WR + T_RP : T_RCD;
   localparam int TMAX  = (T_A > T_B) ? T_A : T_B;
   localparam int TW    = $clog2(TMAX + 1);

   typedef enum logic [3:0] {
      IDLE, PRE, WAIT_RP, ACTV, WAIT_RCD, CAS, WAIT_CAS, WAIT_APRP,
      REF_PRA, WAIT_RPA, REFR, WAIT_RFC
   } state_t;

   state_t              state, state_nxt;
   logic [TW-1:0]       timer;
   logic                timer_done;
   logic [NBANK-1:0]    row_vld;
   logic [ROWWIDTH-1:0] row_tbl [NBANK];
   logic                lat_write, lat_autopre;
   logic [BGW-1:0]      lat_bg;
   logic [BAWIDTH-1:0]  lat_ba;
   logic [ROWWIDTH-1:0] lat_row;
   logic [IDXW-1:0]     req_idx, lat_idx;
   logic                accept;
   logic                cur_write, cur_autopre;
   logic [BGW-1:0]      cur_bg;
   logic [BAWIDTH-1:0]  cur_ba;
   logic [ROWWIDTH-1:0] cur_row;
   logic                act_nxt, pr_nxt, pra_nxt, ref_nxt, cas_nxt;
   logic                rd_nxt, rda_nxt, wr_nxt, wra_nxt, bank_cmd, resp_nxt;

   generate
      if (BGWIDTH > 0) begin : g_bg
         assign req_idx = {req_bg, req_ba};
         assign lat_idx = {lat_bg, lat_ba};
      end else begin : g_nobg
         assign req_idx = req_ba;
         assign lat_idx = lat_ba;
      end
   endgenerate

   assign req_ready  = (state == IDLE) && !ref_req && !reset;
   assign accept     = req_valid && req_ready;
   assign timer_done = (timer <= TW'(1));

   // The first command of a sequence issues straight off the accepting edge, so it must use the live request.
   assign cur_write   = (state == IDLE) ? req_write   : lat_write;
   assign cur_autopre = (state == IDLE) ? req_autopre : lat_autopre;
   assign cur_bg      = (state == IDLE) ? req_bg      : lat_bg;
   assign cur_ba      = (state == IDLE) ? req_ba      : lat_ba;
   assign cur_row     = (state == IDLE) ? req_row     : lat_row;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (ref_req)
               state_nxt = (|row_vld) ? REF_PRA : REFR;
            else if (req_valid) begin
               if (row_vld[req_idx] && row_tbl[req_idx] == req_row) state_nxt = CAS;
               else if (row_vld[req_idx])                            state_nxt = PRE;
               else                                                  state_nxt = ACTV;
            end
         end
         PRE:       state_nxt = WAIT_RP;
         WAIT_RP:   if (timer_done) state_nxt = ACTV;
         ACTV:      state_nxt = WAIT_RCD;
         WAIT_RCD:  if (timer_done) state_nxt = CAS;
         CAS:       state_nxt = WAIT_CAS;
         WAIT_CAS:  if (timer_done) state_nxt = lat_autopre ? WAIT_APRP : IDLE;
         WAIT_APRP: if (timer_done) state_nxt = IDLE;
         REF_PRA:   state_nxt = WAIT_RPA;
         WAIT_RPA:  if (timer_done) state_nxt = REFR;
         REFR:      state_nxt = WAIT_RFC;
         WAIT_RFC:  if (timer_done) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      act_nxt  = (state_nxt == ACTV);
      pr_nxt   = (state_nxt == PRE);
      pra_nxt  = (state_nxt == REF_PRA);
      ref_nxt  = (state_nxt == REFR);
      cas_nxt  = (state_nxt == CAS);
      rd_nxt   = cas_nxt && !cur_write && !cur_autopre;
      rda_nxt  = cas_nxt && !cur_write &&  cur_autopre;
      wr_nxt   = cas_nxt &&  cur_write && !cur_autopre;
      wra_nxt  = cas_nxt &&  cur_write &&  cur_autopre;
      bank_cmd = act_nxt || pr_nxt || cas_nxt;
      resp_nxt = (state == WAIT_CAS) && timer_done;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         {ACT, PR, PRA, RD, RDA, WR, WRA, REF} <= '0;
         ref_ack    <= 1'b0;
         cmd_bg     <= '0;
         cmd_ba     <= '0;
         cmd_row    <= '0;
         resp_valid <= 1'b0;
         resp_write <= 1'b0;
      end else begin
         {ACT, PR, PRA, RD, RDA, WR, WRA, REF} <=
            {act_nxt, pr_nxt, pra_nxt, rd_nxt, rda_nxt, wr_nxt, wra_nxt, ref_nxt};
         ref_ack    <= ref_nxt;
         if (bank_cmd) begin
            cmd_bg <= cur_bg;
            cmd_ba <= cur_ba;
         end
         if (act_nxt) cmd_row <= cur_row;
         resp_valid <= resp_nxt;
         resp_write <= resp_nxt && lat_write;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         {lat_write, lat_autopre} <= 2'b00;
         lat_bg  <= '0;
         lat_ba  <= '0;
         lat_row <= '0;
      end else if (accept) begin
         {lat_write, lat_autopre} <= {req_write, req_autopre};
         lat_bg  <= req_bg;
         lat_ba  <= req_ba;
         lat_row <= req_row;
      end
   end

   // Timer holds the cycles remaining before the next command; waits leave when it reaches 1.
   always_ff @(posedge clk) begin
      if (reset) timer <= '0;
      else begin
         case (state)
            PRE, REF_PRA: timer <= TW'(T_RP - 1);
            ACTV:         timer <= TW'(T_RCD - 1);
            CAS:          timer <= lat_write ? TW'(T_WR - 1) : TW'(BL - 1);
            REFR:         timer <= TW'(T_RFC - 1);
            WAIT_CAS:     timer <= timer_done ? TW'(T_RP) : timer - TW'(1);
            default:      if (timer != '0) timer <= timer - TW'(1);
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) row_vld <= '0;
      else begin
         case (state)
            PRE:     row_vld[lat_idx] <= 1'b0;
            ACTV:    row_vld[lat_idx] <= 1'b1;
            CAS:     if (lat_autopre) row_vld[lat_idx] <= 1'b0;
            REF_PRA: row_vld <= '0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == ACTV) row_tbl[lat_idx] <= lat_row;
   end
endmodule

// File: doc/ddr_cmd_sequencer.md
Name: ddr_cmd_sequencer

Overview:
- Controller-side command issuer that drives the ACT/PR/PRA/RD/RDA/WR/WRA/REF command strobes and bank address into the bank TimingFSM.
- Converts single read/write requests and refresh requests into legal command sequences that meet tRCD/tRP/tWR/tRFC/burst spacing.
- Tracks the open row per bank (open-page policy).
- Serialises commands: at most one command in flight, one global timer.

Parameters:
BGWIDTH, 2, bank-group address width (0 = no bank groups, DDR3)
BAWIDTH, 2, bank address width
ROWWIDTH, 16, row address width
BL, 8, burst length in cycles (read occupancy)
T_RCD, 17, ACT to RD/WR, cycles
T_RP, 17, PR/PRA to next command, cycles
T_WR, 14, WR to next command, cycles
T_RFC, 34, REF to next command, cycles

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_autopre  in  1  use RDA/WRA and close the row afterwards
req_bg  in  max(BGWIDTH,1)  bank group
req_ba  in  BAWIDTH  bank
req_row  in  ROWWIDTH  row
ref_req  in  1  refresh request, level, held until ref_ack
ref_ack  out  1  one-cycle pulse in the cycle REF is issued
ACT, PR, PRA, RD, RDA, WR, WRA, REF  out  1 each  command strobes, at most one high per cycle
cmd_bg  out  max(BGWIDTH,1)  bank group of the issued command
cmd_ba  out  BAWIDTH  bank of the issued command
cmd_row  out  ROWWIDTH  row (valid with ACT)
resp_valid  out  1  one-cycle pulse when a request's CAS spacing completes
resp_write  out  1  type of the completed request, valid with resp_valid

Behaviour:
- Reset values: all outputs 0, including req_ready. Open-row table fully invalid. State IDLE, timer 0. Reset in any state aborts the sequence, and the next cycle shows reset values.
- Commands are registered outputs. Every strobe is high for exactly one cycle. cmd_bg/cmd_ba/cmd_row hold their value from the last command and update only when a command issues.
- States: IDLE, PRE, WAIT_RP, ACTV, WAIT_RCD, CAS, WAIT_CAS, WAIT_APRP, REF_PRA, WAIT_RPA, REFR, WAIT_RFC.
- req_ready = (state == IDLE) && !ref_req && !reset. Refresh has priority over a simultaneous request.
- On acceptance, latch the request. Next state depends on the target bank:
  - Row hit (valid, same row) -> CAS.
  - Empty bank -> ACTV.
  - Conflict (valid, different row) -> PRE.
- PRE: issue PR, clear the bank entry -> WAIT_RP.
- ACTV: issue ACT with row, set the entry -> WAIT_RCD.
- Spacing from an issued command in cycle t to the next command:
  - ACT: RD/WR in cycle t+T_RCD.
  - PR: ACT in cycle t+T_RP.
  - WR: next command no earlier than t+T_WR.
  - RD: next command no earlier than t+BL.
  - WRA: next command no earlier than t+T_WR+T_RP.
  - RDA: next command no earlier than t+BL+T_RP.
  - PRA: REF at t+T_RP.
  - REF: next command no earlier than t+T_RFC.
- CAS: issue RD/WR/RDA/WRA -> WAIT_CAS. Auto-precharge clears the bank entry at issue.
- resp_valid: pulses in cycle t+BL (read) or t+T_WR (write), where t is the CAS cycle. For auto-precharge, the FSM then enters WAIT_APRP for T_RP cycles before IDLE. Otherwise it returns to IDLE in that same cycle.
- Refresh taken in IDLE with ref_req:
  - Any entry valid -> REF_PRA: issue PRA, clear the table, WAIT_RPA for T_RP cycles.
  - Then REFR: issue REF with ref_ack -> WAIT_RFC for T_RFC cycles -> IDLE.
- Timer: down-counter loaded with (delay-1) at issue. It must be wide enough for T_RFC and for BL+T_RP.
- ref_req rising during a request sequence is serviced only after that sequence returns to IDLE.

Test Plan:
- Reset, then read to bg1/ba1 row 0x0123 at cycle 0 (empty bank) -> ACT at 1 with cmd_row=0x0123, RD at 18, resp_valid at 26 with resp_write=0, req_ready high again at 26.
- Second write to the same row (hit), accepted at cycle c -> WR at c+1, no ACT/PR, resp_valid at c+15 with resp_write=1.
- Write to bg1/ba1 row 0x0456 (conflict) at c -> PR at c+1, ACT at c+18, WR at c+35.
- ref_req held with the bank open -> PRA, REF 17 cycles later with ref_ack, req_ready low until 34 cycles after REF. A subsequent read shows ACT (table cleared).
- RDA to an empty bank at 0 -> ACT at 1, RDA at 18, resp_valid at 26, req_ready at 43. The next request to that bank issues ACT with no PR.
- reset asserted during WAIT_RCD -> all strobes/req_ready/resp_valid 0 on the next cycle. A following read to the same bank issues ACT first.
